// File: rtl/tx_pkg.sv
// Shared types and line constants for the NRZI serializer.
// Optional bit stuffing is enabled by defining TX_BIT_STUFF_EN.
package tx_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 8;

   // Line symbols as {D+, D-}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam logic [2:0] ONES_MAX = 3'd6;

`ifdef TX_BIT_STUFF_EN
   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      STUFF,
      EOP_SE0,
      EOP_J
   } tx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      EOP_SE0,
      EOP_J
   } tx_state_t;
`endif

   function automatic logic [1:0] line_toggle(input logic [1:0] line);
      return (line == LINE_J) ? LINE_K : LINE_J;
   endfunction

endpackage

// File: rtl/tx_flex_pts_sr.sv
// Parallel-to-serial shift register; SHIFT_MSB selects which end leaves first.
module tx_flex_pts_sr #(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_enable,
   input  logic                shift_enable,
   input  logic [NUM_BITS-1:0] parallel_in,
   output logic                serial_out
);

   logic [NUM_BITS-1:0] r_data;

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
      end else if (load_enable) begin
         r_data <= parallel_in;
      end else if (shift_enable) begin
         if (SHIFT_MSB) r_data <= {r_data[NUM_BITS-2:0], 1'b0};
         else           r_data <= {1'b0, r_data[NUM_BITS-1:1]};
      end
   end

   assign serial_out = SHIFT_MSB ? r_data[NUM_BITS-1] : r_data[0];

endmodule

// File: rtl/tx_nrzi_serializer.sv
// NRZI line serializer with one-word holding register and SE0/SE0/J end-of-packet.
// Bit stuffing after six consecutive ones is present only when TX_BIT_STUFF_EN is defined.
module tx_nrzi_serializer #(
   parameter int NUM_BITS     = 8,
   parameter int CLKS_PER_BIT = tx_pkg::DEFAULT_CLKS_PER_BIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BITS-1:0] tx_data,
   input  logic                tx_valid,
   input  logic                tx_last,
   output logic                tx_ready,
   output logic                dplus_out,
   output logic                dminus_out,
   output logic                tx_busy,
   output logic                tx_err
);
   import tx_pkg::*;

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [TW-1:0] TIMER_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TIMER_SHIFT = TW'(CLKS_PER_BIT - 2);
   localparam logic [BW-1:0] BIT_LAST    = BW'(NUM_BITS - 1);

   tx_state_t           r_state;
   logic [TW-1:0]       r_timer;
   logic [BW-1:0]       r_bit_cnt;
   logic                r_eop_cnt;
   logic [1:0]          r_line;
   logic                r_busy;
   logic                r_err;
   logic                r_cur_last;
   logic [NUM_BITS-1:0] r_hold_data;
   logic                r_hold_last;
   logic                r_hold_full;
`ifdef TX_BIT_STUFF_EN
   logic [2:0]          r_ones;
`endif

   logic w_ready;
   logic w_accept;
   logic w_bit_end;
   logic w_period_end;
   logic w_last_bit;
   logic w_stuff_now;
   logic w_next_data;
   logic w_word_done;
   logic w_load;
   logic w_to_eop;
   logic w_emit;
   logic w_emit_bit;
   logic w_shift;
   logic w_sr_out;

   assign w_ready   = !r_hold_full && (r_state != EOP_SE0) && (r_state != EOP_J);
   assign w_accept  = tx_valid && w_ready;
   assign w_bit_end = (r_timer == TIMER_LAST);

`ifdef TX_BIT_STUFF_EN
   assign w_period_end = w_bit_end && ((r_state == SHIFT) || (r_state == STUFF));
   assign w_stuff_now  = w_bit_end && (r_state == SHIFT) && (r_ones == ONES_MAX);
`else
   assign w_period_end = w_bit_end && (r_state == SHIFT);
   assign w_stuff_now  = 1'b0;
`endif

   assign w_last_bit  = (r_bit_cnt == BIT_LAST);
   assign w_next_data = w_period_end && !w_stuff_now && !w_last_bit;
   assign w_word_done = w_period_end && !w_stuff_now && w_last_bit;
   assign w_load      = ((r_state == IDLE) && r_hold_full) ||
                        (w_word_done && !r_cur_last && r_hold_full);
   assign w_to_eop    = w_word_done && (r_cur_last || !r_hold_full);
   assign w_emit      = w_load || w_next_data;
   assign w_emit_bit  = w_load ? r_hold_data[0] : w_sr_out;

   // Shift one cycle early so the next bit is already on serial_out at the boundary.
   assign w_shift = (r_state == SHIFT) && (r_timer == TIMER_SHIFT) && !w_last_bit;

   tx_flex_pts_sr #(
      .NUM_BITS  (NUM_BITS),
      .SHIFT_MSB (1'b0)
   ) u_sr (
      .clk          (clk),
      .rst          (rst),
      .load_enable  (w_load),
      .shift_enable (w_shift),
      .parallel_in  (r_hold_data),
      .serial_out   (w_sr_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_timer     <= '0;
         r_bit_cnt   <= '0;
         r_eop_cnt   <= 1'b0;
         r_line      <= LINE_J;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_cur_last  <= 1'b0;
         // NOTE: the holding register is reset too, so no stale word can start a packet.
         r_hold_data <= '0;
         r_hold_last <= 1'b0;
         r_hold_full <= 1'b0;
`ifdef TX_BIT_STUFF_EN
         r_ones      <= '0;
`endif
      end else begin
         r_err <= 1'b0;

         if ((r_state == IDLE) || w_bit_end) r_timer <= '0;
         else                                r_timer <= r_timer + 1'b1;

         if (w_accept) begin
            r_hold_data <= tx_data;
            r_hold_last <= tx_last;
            r_hold_full <= 1'b1;
         end

         if (w_load) begin
            r_hold_full <= 1'b0;
            r_cur_last  <= r_hold_last;
            r_bit_cnt   <= '0;
         end else if (w_next_data) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end

         if (w_emit) begin
            r_line <= w_emit_bit ? r_line : line_toggle(r_line);
`ifdef TX_BIT_STUFF_EN
            r_ones <= w_emit_bit ? r_ones + 3'd1 : 3'd0;
`endif
         end

         case (r_state)
            IDLE: begin
               if (r_hold_full) begin
                  r_state <= SHIFT;
                  r_busy  <= 1'b1;
               end
            end
`ifdef TX_BIT_STUFF_EN
            SHIFT, STUFF: begin
               if (w_stuff_now) begin
                  r_state <= STUFF;
                  r_line  <= line_toggle(r_line);
                  r_ones  <= '0;
               end else if (w_emit) begin
`else
            SHIFT: begin
               if (w_emit) begin
`endif
                  r_state <= SHIFT;
               end else if (w_to_eop) begin
                  r_state   <= EOP_SE0;
                  r_line    <= LINE_SE0;
                  r_eop_cnt <= 1'b0;
                  r_err     <= !r_cur_last;
`ifdef TX_BIT_STUFF_EN
                  r_ones    <= '0;
`endif
               end
            end
            EOP_SE0: begin
               if (w_bit_end) begin
                  if (r_eop_cnt) begin
                     r_state <= EOP_J;
                     r_line  <= LINE_J;
                  end else begin
                     r_eop_cnt <= 1'b1;
                  end
               end
            end
            EOP_J: begin
               if (w_bit_end) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_ready   = w_ready;
   assign dplus_out  = r_line[1];
   assign dminus_out = r_line[0];
   assign tx_busy    = r_busy;
   assign tx_err     = r_err;

endmodule

// File: doc/tx_nrzi_serializer.md
TX_NRZI_SERIALIZER -- requirements
Module: tx_nrzi_serializer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8: width of one transmitted data word.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 8: clk cycles per line bit period, range 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port tx_data, input, NUM_BITS bits: word to send, LSB first.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data and tx_last are valid.
REQ-007 SHALL have port tx_last, input, 1 bit: the accepted word is the final word of the packet.
REQ-008 SHALL have port tx_ready, output, 1 bit: holding register is empty.
REQ-009 SHALL have port dplus_out, output, 1 bit: D+ line drive.
REQ-010 SHALL have port dminus_out, output, 1 bit: D- line drive.
REQ-011 SHALL have port tx_busy, output, 1 bit: high from packet start until EOP is complete.
REQ-012 SHALL have port tx_err, output, 1 bit: one-cycle pulse on underrun.

Function
REQ-013 A word SHALL be accepted on any clk edge where tx_valid and tx_ready are both high; tx_ready SHALL drop on the next cycle.
REQ-014 The one-word holding register SHALL allow the next word to be accepted while the current word shifts.
REQ-015 States SHALL be IDLE, SHIFT, STUFF, EOP_SE0 and EOP_J.
REQ-016 IDLE to SHIFT: the first bit period SHALL begin on the cycle after acceptance (latency 1).
REQ-017 A bit timer SHALL count 0 to CLKS_PER_BIT-1; a bit boundary SHALL occur at terminal count; outputs SHALL change only at boundaries and SHALL be registered.
REQ-018 NRZI encoding: a 0 bit SHALL toggle the line between J (D+=1, D-=0) and K (D+=0, D-=1); a 1 bit SHALL hold the line.
REQ-019 A ones counter (0 to 6) SHALL increment on each 1 bit and clear on each 0 bit.
REQ-020 On reaching 6, one STUFF bit period (a toggle) SHALL be inserted before the next data bit, and the ones counter SHALL clear.
REQ-021 Stuffing SHALL also apply after the final data bit of a packet, before EOP.
REQ-022 At the end of a word, if the holding register is full, the shifter SHALL load it with no gap bit period, and the ones counter SHALL carry across words.
REQ-023 At the end of a word with tx_last latched, the block SHALL go to EOP_SE0: D+=0 and D-=0 for 2 bit periods, then EOP_J: J for 1 bit period, then IDLE.
REQ-024 At the end of a word with the holding register empty and tx_last not latched (underrun), tx_err SHALL pulse for 1 cycle and the block SHALL proceed to EOP_SE0.
REQ-025 tx_ready SHALL be low throughout EOP_SE0 and EOP_J; tx_busy SHALL fall on the cycle IDLE is re-entered.
REQ-026 SE0 SHALL never be driven outside EOP_SE0; D+=D-=1 SHALL never be driven.

Reset
REQ-027 While rst is high, outputs SHALL be: dplus_out=1, dminus_out=0, tx_ready=1, tx_busy=0, tx_err=0; the state SHALL be IDLE and all counters and the holding register SHALL be cleared.
REQ-028 Reset asserted mid-packet SHALL abort the packet immediately, with no EOP driven.

Configuration
REQ-029 With macro TX_BIT_STUFF_EN defined, REQ-019 to REQ-021 SHALL apply.
REQ-030 Without TX_BIT_STUFF_EN, STUFF and the ones counter SHALL be absent, and every word SHALL occupy exactly NUM_BITS bit periods.

Structure
REQ-031 Shared package tx_pkg SHALL hold: the state enum; line constants LINE_J, LINE_K and LINE_SE0 (2-bit {D+,D-}); default CLKS_PER_BIT.
REQ-032 Sub-module tx_flex_pts_sr SHALL be the parallel-to-serial shift register (NUM_BITS, SHIFT_MSB, load_enable, shift_enable, serial_out); the top level instantiates it with SHIFT_MSB=0.

Verification (NUM_BITS=8, CLKS_PER_BIT=8)
REQ-033 Send 0x80 with tx_last=1 -> line sequence K,J,K,J,K,J,K,K, then SE0 for 16 cycles, then J for 8 cycles; tx_busy high for 88 cycles; tx_err=0.
REQ-034 Send 0xFF with tx_last=1 and stuffing enabled -> J for 6 bits, stuffed K, then K,K, then EOP; 9 data bit periods.
REQ-035 Send 0x80 then 0x55 (0x55 with tx_last=1), the second presented while the first shifts -> no idle bit period between words; tx_ready reasserts within 1 cycle of the first load.
REQ-036 Send 0x00 with tx_last=0 and no follow-up word -> 8 toggles, tx_err pulses for 1 cycle at the word end, then full EOP.
REQ-037 Assert rst during bit 3 of 0x3C -> same cycle: J, tx_ready=1, tx_busy=0; a following 0xFF packet stuffs after exactly 6 ones.
REQ-038 Build without TX_BIT_STUFF_EN and send 0xFF -> 8 J bit periods, no K, then EOP.
